// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types used across pipeline stages.
// Holds the fetch-to-execute queue entry bundle.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_ex_entry_t;

endpackage

// File: rtl/fetch_ex_queue_ptr.sv
// Modulo-DEPTH pointer with clear and increment.
// Clear wins over increment; wraps DEPTH-1 -> 0.
module fetch_ex_queue_ptr #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      if (ptr == W'(DEPTH - 1)) ptr_d = '0;
      else ptr_d = ptr + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr <= '0;
    else ptr <= ptr_d;
  end

endmodule

// File: rtl/fetch_ex_queue.sv
// Fetch-to-execute instruction queue with flush.
// Optional same-cycle bypass: define FETCH_EX_BYPASS_EN.
module fetch_ex_queue
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [31:0]      f_pc,
  input  logic [31:0]      f_instr,
  output logic             e_valid,
  input  logic             e_ready,
  output logic [31:0]      e_pc,
  output logic [31:0]      e_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_t;

  occ_t             occ_q, occ_d;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             rst_q;
  logic             push, pop, empty;
  logic             byp_take;

  fetch_ex_entry_t  mem [DEPTH];
  fetch_ex_entry_t  head;

  assign head  = mem[rd_ptr];
  assign empty = (occ_q == EMPTY);

  // Hold f_ready low for the cycle that follows a sampled reset.
  always_ff @(posedge CLK) begin
    rst_q <= RST;
  end

  assign f_ready = !rst_q && (occ_q != FULL);

`ifdef FETCH_EX_BYPASS_EN
  assign e_valid  = empty ? (f_valid && !flush && !rst_q) : !flush;
  assign e_pc     = empty ? f_pc : head.pc;
  assign e_instr  = empty ? f_instr : head.instr;
  assign byp_take = empty && f_valid && f_ready && e_ready && !flush;
`else
  assign e_valid  = !empty && !flush;
  assign e_pc     = head.pc;
  assign e_instr  = head.instr;
  assign byp_take = 1'b0;
`endif

  assign push = f_valid && f_ready && !flush && !byp_take;
  assign pop  = e_valid && e_ready && !flush && !empty;

  always_comb begin
    count_d = count;
    occ_d   = occ_q;
    if (flush) begin
      count_d = '0;
      occ_d   = EMPTY;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          count_d = count + CNT_W'(1);
          occ_d   = (count == CNT_W'(DEPTH - 1)) ? FULL : PARTIAL;
        end
        2'b01: begin
          count_d = count - CNT_W'(1);
          occ_d   = (count == CNT_W'(1)) ? EMPTY : PARTIAL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      occ_q <= EMPTY;
    end else begin
      count <= count_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr] <= '{pc: f_pc, instr: f_instr};
    end
  end

  fetch_ex_queue_ptr #(
    .DEPTH(DEPTH),
    .W    (PTR_W)
  ) u_rd_ptr (
    .CLK(CLK),
    .RST(RST),
    .clr(flush),
    .inc(pop),
    .ptr(rd_ptr)
  );

  fetch_ex_queue_ptr #(
    .DEPTH(DEPTH),
    .W    (PTR_W)
  ) u_wr_ptr (
    .CLK(CLK),
    .RST(RST),
    .clr(flush),
    .inc(push),
    .ptr(wr_ptr)
  );

endmodule

// File: tb/tb_fetch_ex_queue.sv
// Directed bench for fetch_ex_queue (DEPTH 2 and 3).
// Bypass expectations follow FETCH_EX_BYPASS_EN.
module tb_fetch_ex_queue;

  logic        clk = 1'b0;
  logic        rst, flush, f_valid, e_ready;
  logic [31:0] f_pc, f_instr;

  logic        a_f_ready, a_e_valid;
  logic [31:0] a_e_pc, a_e_instr;
  logic [1:0]  a_count;
  logic        b_f_ready, b_e_valid;
  logic [31:0] b_e_pc, b_e_instr;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ex_queue #(.DEPTH(2)) u_a (
    .CLK(clk), .RST(rst), .flush(flush),
    .f_valid(f_valid), .f_ready(a_f_ready),
    .f_pc(f_pc), .f_instr(f_instr),
    .e_valid(a_e_valid), .e_ready(e_ready),
    .e_pc(a_e_pc), .e_instr(a_e_instr),
    .count(a_count)
  );

  fetch_ex_queue #(.DEPTH(3)) u_b (
    .CLK(clk), .RST(rst), .flush(flush),
    .f_valid(f_valid), .f_ready(b_f_ready),
    .f_pc(f_pc), .f_instr(f_instr),
    .e_valid(b_e_valid), .e_ready(e_ready),
    .e_pc(b_e_pc), .e_instr(b_e_instr),
    .count(b_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic er,
                       input logic [31:0] pc);
    f_valid = fv;
    e_ready = er;
    f_pc    = pc;
    f_instr = pc ^ 32'hA5A5_0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step(); step();
    checks++;
    if (a_count !== 2'd0) begin
      errors++; $display("FAIL rst_count got %0d want 0", a_count);
    end
    checks++;
    if (a_e_valid !== 1'b0) begin
      errors++; $display("FAIL rst_e_valid got %b want 0", a_e_valid);
    end
    checks++;
    if (a_f_ready !== 1'b0) begin
      errors++; $display("FAIL rst_f_ready got %b want 0", a_f_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (a_f_ready !== 1'b1 || b_f_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_f_ready got %b/%b want 1/1",
               a_f_ready, b_f_ready);
    end
  endtask

  task automatic test_fill_drain();
    logic exp_ev;
`ifdef FETCH_EX_BYPASS_EN
    exp_ev = 1'b1;
`else
    exp_ev = 1'b0;
`endif
    drive(1'b1, 1'b0, 32'h100);
    #1;
    checks++;
    if (a_e_valid !== exp_ev) begin
      errors++; $display("FAIL fd_latency got %b want %b", a_e_valid, exp_ev);
    end
    step();
    checks++;
    if (a_count !== 2'd1 || a_e_pc !== 32'h100) begin
      errors++;
      $display("FAIL fd_first got cnt %0d pc %h want 1 100", a_count, a_e_pc);
    end
    drive(1'b1, 1'b0, 32'h104);
    step();
    checks++;
    if (a_count !== 2'd2 || a_f_ready !== 1'b0) begin
      errors++;
      $display("FAIL fd_full got cnt %0d rdy %b want 2 0", a_count, a_f_ready);
    end
    drive(1'b1, 1'b0, 32'h108);
    step();
    checks++;
    if (a_count !== 2'd2 || a_e_pc !== 32'h100) begin
      errors++;
      $display("FAIL fd_third got cnt %0d pc %h want 2 100", a_count, a_e_pc);
    end
    drive(1'b0, 1'b1, 32'h0);
    #1;
    checks++;
    if (a_e_pc !== 32'h100 || a_e_instr !== (32'h100 ^ 32'hA5A5_0000)) begin
      errors++;
      $display("FAIL fd_pop0 got %h/%h want 100/a5a50100", a_e_pc, a_e_instr);
    end
    step();
    checks++;
    if (a_e_pc !== 32'h104 || a_count !== 2'd1) begin
      errors++;
      $display("FAIL fd_pop1 got pc %h cnt %0d want 104 1", a_e_pc, a_count);
    end
    step();
    checks++;
    if (a_e_valid !== 1'b0 || a_count !== 2'd0) begin
      errors++;
      $display("FAIL fd_empty got ev %b cnt %0d want 0 0",
               a_e_valid, a_count);
    end
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    logic [1:0]  exp_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 32'(4 * i));
      #1;
`ifdef FETCH_EX_BYPASS_EN
      exp_pc  = 32'(4 * i);
      exp_cnt = 2'd0;
`else
      exp_pc  = 32'(4 * (i - 1));
      exp_cnt = 2'd1;
`endif
      if (i > 0) begin
        checks++;
        if (a_e_valid !== 1'b1 || a_e_pc !== exp_pc || a_count !== exp_cnt)
        begin
          errors++;
          $display("FAIL stream_%0d got ev %b pc %h cnt %0d want 1 %h %0d",
                   i, a_e_valid, a_e_pc, a_count, exp_pc, exp_cnt);
        end
      end
      step();
    end
    drive(1'b0, 1'b1, 32'h0);
    step();
    checks++;
    if (a_count !== 2'd0 || a_e_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got cnt %0d ev %b want 0 0",
               a_count, a_e_valid);
    end
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 32'h1F0);
    step();
    drive(1'b1, 1'b0, 32'h1F4);
    step();
    checks++;
    if (a_count !== 2'd2) begin
      errors++; $display("FAIL fl_fill got %0d want 2", a_count);
    end
    flush = 1'b1;
    drive(1'b1, 1'b0, 32'h200);
    #1;
    checks++;
    if (a_e_valid !== 1'b0) begin
      errors++; $display("FAIL fl_e_valid got %b want 0", a_e_valid);
    end
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (a_count !== 2'd0 || a_e_valid !== 1'b0) begin
      errors++;
      $display("FAIL fl_after got cnt %0d ev %b want 0 0", a_count, a_e_valid);
    end
    drive(1'b1, 1'b0, 32'h210);
    step();
    drive(1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (a_count !== 2'd1 || a_e_pc !== 32'h210) begin
      errors++;
      $display("FAIL fl_nostore got cnt %0d pc %h want 1 210",
               a_count, a_e_pc);
    end
    drive(1'b0, 1'b1, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    int          pushes = 0;
    int          pops   = 0;
    int          s;
    logic        fv, er, took;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 60 && pops < 10; i++) begin
      fv = (pushes < 10) && (i % 4 != 3);
      er = (i % 3 != 0) || (pushes >= 10);
      drive(fv, er, 32'h400 + 32'(4 * pushes));
      #1;
      s    = q.size();
      took = 1'b0;
      checks++;
      if (b_f_ready !== (s < 3)) begin
        errors++;
        $display("FAIL wrap_rdy_%0d got %b want %b", i, b_f_ready, s < 3);
      end
      if (er && s > 0) begin
        checks++;
        if (b_e_valid !== 1'b1 || b_e_pc !== q[0]) begin
          errors++;
          $display("FAIL wrap_pop_%0d got ev %b pc %h want 1 %h",
                   i, b_e_valid, b_e_pc, q[0]);
        end
        void'(q.pop_front());
        pops++;
      end
`ifdef FETCH_EX_BYPASS_EN
      else if (er && fv && s == 0) begin
        checks++;
        if (b_e_valid !== 1'b1 || b_e_pc !== f_pc) begin
          errors++;
          $display("FAIL wrap_byp_%0d got ev %b pc %h want 1 %h",
                   i, b_e_valid, b_e_pc, f_pc);
        end
        took = 1'b1;
        pops++;
        pushes++;
      end
`endif
      if (fv && s < 3 && !took) begin
        q.push_back(f_pc);
        pushes++;
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (pops != 10 || b_count !== 2'd0) begin
      errors++;
      $display("FAIL wrap_total got pops %0d cnt %0d want 10 0",
               pops, b_count);
    end
  endtask

  task automatic test_reset_mid();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 1'b0, 32'h500);
    step();
    drive(1'b1, 1'b0, 32'h504);
    step();
    checks++;
    if (a_count !== 2'd2) begin
      errors++; $display("FAIL rm_fill got %0d want 2", a_count);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h508);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (a_count !== 2'd0 || a_e_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_clear got cnt %0d ev %b want 0 0",
               a_count, a_e_valid);
    end
    step();
    checks++;
    if (a_f_ready !== 1'b1 || a_count !== 2'd0) begin
      errors++;
      $display("FAIL rm_ready got rdy %b cnt %0d want 1 0",
               a_f_ready, a_count);
    end
  endtask

`ifdef FETCH_EX_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 1'b1, 32'h300);
    #1;
    checks++;
    if (a_e_valid !== 1'b1 || a_e_pc !== 32'h300) begin
      errors++;
      $display("FAIL byp_same got ev %b pc %h want 1 300", a_e_valid, a_e_pc);
    end
    step();
    drive(1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (a_count !== 2'd0) begin
      errors++; $display("FAIL byp_count got %0d want 0", a_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_EX_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ex_queue.md
FETCH_EX_QUEUE -- requirements
Module: fetch_ex_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered fetch-to-execute entries; legal range 1..16.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 flush  input  1  branch/jump redirect from execute; discards all queued entries.
REQ-006 f_valid  input  1  fetch presents an entry.
REQ-007 f_ready  output  1  queue accepts an entry this cycle.
REQ-008 f_pc  input  32  PC of the fetched instruction (word_t).
REQ-009 f_instr  input  32  fetched instruction word (word_t).
REQ-010 e_valid  output  1  head entry available to execute.
REQ-011 e_ready  input  1  execute consumes the head entry this cycle.
REQ-012 e_pc  output  32  PC of the head entry.
REQ-013 e_instr  output  32  instruction of the head entry.
REQ-014 count  output  CNT_W  number of stored entries.

Function
REQ-015 Push occurs when f_valid && f_ready && !flush; pop occurs when e_valid && e_ready && !flush.
REQ-016 f_ready SHALL equal (count < DEPTH); no push on a full queue, even with a simultaneous pop.
REQ-017 e_valid SHALL equal (count != 0) && !flush; e_pc/e_instr SHALL show the head entry, and are don't-care when e_valid is 0.
REQ-018 Entries leave in push order; the read and write pointers wrap from DEPTH-1 to 0, so DEPTH need not be a power of two.
REQ-019 On a simultaneous push and pop, count is unchanged and both pointers advance.
REQ-020 Without bypass, an entry pushed in cycle N is first visible on e_* in cycle N+1.
REQ-021 Flush has priority over push and pop: in the flush cycle nothing is stored or consumed; the next cycle has count 0 and both pointers 0.
REQ-022 The occupancy state is EMPTY (count 0), PARTIAL, or FULL (count DEPTH); it changes only through push, pop, flush, or reset.
REQ-023 Stored payload SHALL be held stable while the entry is not popped.

Reset
REQ-024 While RST is high at a clock edge, count, both pointers, e_valid and f_ready SHALL be cleared to 0 in the following cycle, and f_ready SHALL return to 1 in the first cycle after RST deasserts.
REQ-025 RST overrides flush, push and pop; payload storage is not reset.
REQ-026 When RST asserts mid-operation, all queued entries are lost, with no partial pop.

Configuration
REQ-027 When the macro FETCH_EX_BYPASS_EN is defined and count is 0, e_valid SHALL equal f_valid && !flush and e_pc/e_instr SHALL equal f_pc/f_instr combinationally.
REQ-028 With FETCH_EX_BYPASS_EN defined, a bypassed entry accepted by e_ready in the same cycle SHALL NOT be stored.
REQ-029 With FETCH_EX_BYPASS_EN defined, f_ready is unchanged from REQ-016.
REQ-030 When FETCH_EX_BYPASS_EN is undefined, REQ-020 applies (minimum latency of one cycle).

Structure
REQ-031 The typedef fetch_ex_entry_t {word_t pc; word_t instr;} SHALL be added to rv32i_types_pkg, and storage SHALL be an array of this type.
REQ-032 A single sub-module, fetch_ex_queue_ptr, SHALL implement one modulo-DEPTH pointer with increment and clear; it is instantiated twice (read and write).
REQ-033 No other constants are added to the package; DEPTH stays a module parameter.

Verification
REQ-034 Fill/drain with DEPTH=2, e_ready=0: push PC 0x100 then 0x104 -> count 2, f_ready 0; a third push is ignored; then e_ready=1 -> pops 0x100, then 0x104, then e_valid 0.
REQ-035 Steady stream with DEPTH=2, f_valid=e_ready=1 every cycle, PCs 0x0, 0x4, 0x8... -> one pop per cycle, in order, with count constant at 1 (0 with bypass).
REQ-036 Flush with count 2 while f_valid=1 (PC 0x200) -> e_valid 0 in the flush cycle, count 0 next cycle, and 0x200 is not stored.
REQ-037 Wrap with DEPTH=3: 10 pushes interleaved with pops -> the output PC sequence matches the input order exactly across pointer wrap.
REQ-038 Reset mid-stream with count 2: RST=1 for one cycle -> count 0 and e_valid 0; f_ready 1 in the first cycle after RST deasserts.
REQ-039 Bypass (FETCH_EX_BYPASS_EN defined), empty queue, f_valid=e_ready=1, PC 0x300 -> e_pc 0x300 in the same cycle, and count stays 0.
